// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage M-extension unit for the RV32IM pipeline.
// Multiplies over a fixed two-edge path and divides with a 32-step
// restoring divider. BUSY stalls the front of the pipeline while an
// operation is in flight. DONE pulses for one cycle with RESULT valid.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [5:0]      DIV_STEPS = 6'(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [2:0]      func3_q;
  logic [XLEN:0]   mul_a_q;     // operand with its sign-extension bit
  logic [XLEN:0]   mul_b_q;
  logic [XLEN-1:0] quo_q;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] divisor_q;
  logic [5:0]      count_q;
  logic            q_neg_q;
  logic            r_neg_q;

  // Operand decode at acceptance time, from the raw ID/EX inputs.
  logic            a_mul_signed;
  logic            b_mul_signed;
  logic            div_signed;
  logic            div_is_rem;
  logic            div_by_zero;
  logic            div_overflow;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] special_result;

  // Datapath values derived from the latched state.
  logic [2*XLEN-1:0] mul_a64;
  logic [2*XLEN-1:0] mul_b64;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_result;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic              step_ok;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   div_result;

  // Decode sign handling and the divide special cases for a new op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    a_mul_signed   = (FUNC3[1:0] != 2'b11);
    b_mul_signed   = ~FUNC3[1];
    div_signed     = ~FUNC3[0];
    div_is_rem     = FUNC3[1];
    div_by_zero    = (OPERAND_B == '0);
    div_overflow   = div_signed && (OPERAND_A == MOST_NEG) && (OPERAND_B == ALL_ONES);
    a_abs          = (div_signed && OPERAND_A[XLEN-1]) ? -OPERAND_A : OPERAND_A;
    b_abs          = (div_signed && OPERAND_B[XLEN-1]) ? -OPERAND_B : OPERAND_B;
    special_result = '0;
    if (div_by_zero) begin
      special_result = div_is_rem ? OPERAND_A : ALL_ONES;
    end else if (div_overflow) begin
      special_result = div_is_rem ? '0 : MOST_NEG;
    end
  end

  // Full 64-bit product of the sign-extended latched operands.
  always_comb begin
    mul_a64    = {{(XLEN-1){mul_a_q[XLEN]}}, mul_a_q};
    mul_b64    = {{(XLEN-1){mul_b_q[XLEN]}}, mul_b_q};
    product    = mul_a64 * mul_b64;
    mul_result = (func3_q == 3'b000) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // One restoring divide step plus the sign-corrected final answer.
  always_comb begin
    rem_shift  = {rem_q, quo_q[XLEN-1]};
    rem_diff   = rem_shift - {1'b0, divisor_q};
    step_ok    = ~rem_diff[XLEN];
    rem_next   = step_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next   = {quo_q[XLEN-2:0], step_ok};
    div_result = func3_q[1] ? (r_neg_q ? -rem_next : rem_next)
                            : (q_neg_q ? -quo_next : quo_next);
  end

  // Control FSM with registered BUSY/DONE/RESULT and the datapath state.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: all internal datapath registers are reset too, so a mid-op reset leaves no stale divider state behind.
    if (!RST_N) begin
      state     <= S_IDLE;
      RESULT    <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      func3_q   <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          if (START && !FLUSH) begin
            func3_q <= FUNC3;
            if (!FUNC3[2]) begin
              mul_a_q <= {a_mul_signed & OPERAND_A[XLEN-1], OPERAND_A};
              mul_b_q <= {b_mul_signed & OPERAND_B[XLEN-1], OPERAND_B};
              state   <= S_MUL;
              BUSY    <= 1'b1;
            end else if (div_by_zero || div_overflow) begin
              RESULT <= special_result;
              state  <= S_FIN;
              DONE   <= 1'b1;
            end else begin
              quo_q     <= a_abs;
              divisor_q <= b_abs;
              rem_q     <= '0;
              count_q   <= DIV_STEPS;
              q_neg_q   <= div_signed && (OPERAND_A[XLEN-1] ^ OPERAND_B[XLEN-1]);
              r_neg_q   <= div_signed && OPERAND_A[XLEN-1];
              state     <= S_DIV;
              BUSY      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (FLUSH) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            RESULT <= mul_result;
            state  <= S_FIN;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
          end
        end
        S_DIV: begin
          if (FLUSH) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            quo_q   <= quo_next;
            rem_q   <= rem_next;
            count_q <= count_q - 6'd1;
            if (count_q == 6'd1) begin
              RESULT <= div_result;
              state  <= S_FIN;
              BUSY   <= 1'b0;
              DONE   <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit.
// Expected values are hand-computed constants in the stimulus calls.
module tb_ex_muldiv_unit;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        FLUSH;
  logic [2:0]  FUNC3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int tests_run;
  int tests_failed;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .FLUSH     (FLUSH),
    .FUNC3     (FUNC3),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .RESULT    (RESULT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for DONE, counting edges from acceptance and BUSY cycles.
  // Called #1 after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 1;
    busy_cycles = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busy_cycles++;
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  // Issue one op from a negedge and check latency, BUSY length and RESULT.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_result,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy_cycles;
    @(negedge CLK);
    START     = 1'b1;
    FUNC3     = f3;
    OPERAND_A = a;
    OPERAND_B = b;
    @(posedge CLK);
    #1;
    START     = 1'b0;
    FUNC3     = 3'b000;
    OPERAND_A = 32'hDEAD_BEEF;
    OPERAND_B = 32'h1234_5678;
    wait_done(lat, busy_cycles);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_cycles), 32'(exp_busy));
    check({tag, "_result"}, RESULT, exp_result);
  endtask

  initial begin
    int lat;
    int busy_cycles;
    logic [31:0] held;
    logic seen_done;

    tests_run    = 0;
    tests_failed = 0;
    RST_N     = 1'b0;
    START     = 1'b0;
    FLUSH     = 1'b0;
    FUNC3     = 3'b000;
    OPERAND_A = '0;
    OPERAND_B = '0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_result", RESULT, 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Multiplies: latency 2, one BUSY cycle.
    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2, 1);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1);

    // Normal divides: latency 33, 32 BUSY cycles.
    run_op("div_neg",  3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33, 32);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33, 32);
    run_op("rem_negb", 3'b110, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 33, 32);
    run_op("divu",     3'b101, 32'd100, 32'd7, 32'd14, 33, 32);
    run_op("remu",     3'b111, 32'd100, 32'd7, 32'd2, 33, 32);

    // Special cases: straight to FIN, BUSY never high.
    run_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    // Back-to-back: START held, MUL 6x7 then DIVU 100/7 presented in FIN.
    @(negedge CLK);
    START     = 1'b1;
    FUNC3     = 3'b000;
    OPERAND_A = 32'd6;
    OPERAND_B = 32'd7;
    @(posedge CLK);
    #1;
    check("b2b_mul_busy", 32'(BUSY), 32'h1);
    @(posedge CLK);
    #1;
    check("b2b_mul_done", 32'(DONE), 32'h1);
    check("b2b_mul_result", RESULT, 32'd42);
    FUNC3     = 3'b101;
    OPERAND_A = 32'd100;
    OPERAND_B = 32'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("b2b_div_busy", 32'(BUSY), 32'h1);
    check("b2b_div_done", 32'(DONE), 32'h0);
    wait_done(lat, busy_cycles);
    check("b2b_div_lat", 32'(lat), 32'd33);
    check("b2b_div_result", RESULT, 32'd14);

    // FLUSH at divide iteration 10.
    held = RESULT;
    @(negedge CLK);
    START     = 1'b1;
    FUNC3     = 3'b100;
    OPERAND_A = 32'hFFFF_FFEC;
    OPERAND_B = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    check("flush_pre_busy", 32'(BUSY), 32'h1);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    check("flush_busy", 32'(BUSY), 32'h0);
    check("flush_done", 32'(DONE), 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) seen_done = 1'b1;
    end
    check("flush_no_done", 32'(seen_done), 32'h0);
    check("flush_result_held", RESULT, held);
    run_op("post_flush_divu", 3'b101, 32'd9, 32'd2, 32'd4, 33, 32);

    // Asynchronous reset mid-divide, between edges.
    @(negedge CLK);
    START     = 1'b1;
    FUNC3     = 3'b101;
    OPERAND_A = 32'd1000;
    OPERAND_B = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("arst_busy", 32'(BUSY), 32'h0);
    check("arst_done", 32'(DONE), 32'h0);
    check("arst_result", RESULT, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 32'd12, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
